// File: rtl/act_hard_sigmoid.sv
// act_hard_sigmoid: element-serial hard-sigmoid activation over an N-wide vector.
// A vector is captured in IDLE, one element per cycle is activated in PROC, and
// the finished vector is presented in HOLD until the consumer takes it.
// Per element: x >= 2 -> 1.0, x <= -2 -> 0.0, otherwise x/4 + 0.5 (floor shift).
// o_sat_cnt reports how many elements of the current vector hit a clamp.

module act_hard_sigmoid #(
    parameter int BITSIZE = 16,
    parameter int FRAC    = 8,
    parameter int N       = 6
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [BITSIZE*N-1:0] i_x,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [BITSIZE*N-1:0] o_y,
    output logic [3:0]           o_sat_cnt
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    localparam logic signed [BITSIZE-1:0] C_ONE     = BITSIZE'(1 << FRAC);
    localparam logic signed [BITSIZE-1:0] C_HALF    = BITSIZE'(1 << (FRAC - 1));
    localparam logic signed [BITSIZE-1:0] C_TWO     = BITSIZE'(2 << FRAC);
    localparam logic signed [BITSIZE-1:0] C_NEG_TWO = BITSIZE'(-(2 << FRAC));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PROC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [BITSIZE*N-1:0]   r_x;
    logic [IDX_W-1:0]       r_idx;
    logic [BITSIZE*N-1:0]   r_y;
    logic [3:0]             r_sat_cnt;
    logic                   r_out_valid;
    logic                   r_in_ready;

    logic                   w_accept;
    logic                   w_last;
    logic                   w_in_ready_nxt;
    logic                   w_out_valid_nxt;
    logic                   w_proc;

    logic signed [BITSIZE-1:0] w_elem;
    logic signed [BITSIZE-1:0] w_shift;
    logic signed [BITSIZE-1:0] w_res;
    logic                      w_clamp;

    // Handshake qualifiers: r_in_ready is only ever high in IDLE.
    assign w_accept = i_in_valid & r_in_ready & (r_state == IDLE);
    assign w_last   = (r_idx == LAST_IDX);
    assign w_proc   = (r_state == PROC);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: accept, walk all elements, then wait for the consumer.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept)    w_state_nxt = PROC;
            PROC:    if (w_last)      w_state_nxt = HOLD;
            HOLD:    if (i_out_ready) w_state_nxt = IDLE;
            default:                  w_state_nxt = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the handshake flags come out of flops.
    always_comb begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        unique case (w_state_nxt)
            IDLE:    w_in_ready_nxt  = 1'b1;
            HOLD:    w_out_valid_nxt = 1'b1;
            default: begin
                w_in_ready_nxt  = 1'b0;
                w_out_valid_nxt = 1'b0;
            end
        endcase
    end

    // Handshake flag registers; ready is high out of reset so the first vector is taken.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    // Pick the element addressed by the running index out of the captured vector.
    always_comb begin
        w_elem = '0;
        for (int k = 0; k < N; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_elem = r_x[k*BITSIZE +: BITSIZE];
            end
        end
    end

    // Hard-sigmoid of one element; the +/-2 boundaries belong to the clamp branches.
    always_comb begin
        w_shift = w_elem >>> 2;
        w_res   = '0;
        w_clamp = 1'b0;
        if (w_elem >= C_TWO) begin
            w_res   = C_ONE;
            w_clamp = 1'b1;
        end else if (w_elem <= C_NEG_TWO) begin
            w_res   = '0;
            w_clamp = 1'b1;
        end else begin
            w_res   = w_shift + C_HALF;
            w_clamp = 1'b0;
        end
    end

    // Capture the input vector on acceptance and step the element index without wrapping.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x   <= '0;
            r_idx <= '0;
        end else if (w_accept) begin
            r_x   <= i_x;
            r_idx <= '0;
        end else if (w_proc && !w_last) begin
            r_idx <= r_idx + IDX_W'(1);
        end
    end

    // Write one activated element per PROC cycle; y survives until the next PROC overwrites it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_y <= '0;
        end else if (w_proc) begin
            for (int k = 0; k < N; k++) begin
                if (r_idx == IDX_W'(k)) begin
                    r_y[k*BITSIZE +: BITSIZE] <= w_res;
                end
            end
        end
    end

    // Clamp counter: cleared per accepted vector, bumped for each clamped element.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sat_cnt <= '0;
        end else if (w_accept) begin
            r_sat_cnt <= '0;
        end else if (w_proc && w_clamp) begin
            r_sat_cnt <= r_sat_cnt + 4'd1;
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_y         = r_y;
    assign o_sat_cnt   = r_sat_cnt;

endmodule

// File: doc/act_hard_sigmoid.md
ACT_HARD_SIGMOID -- requirements
Module: act_hard_sigmoid

Interface
REQ-001 Parameter BITSIZE, 16, width of one signed fixed-point element.
REQ-002 Parameter FRAC, 8, number of fraction bits (Q(BITSIZE-FRAC).FRAC two's complement).
REQ-003 Parameter N, 6, elements per vector (matches the 6-wide first encoder layer output).
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 in_valid  input  1  upstream vector x valid.
REQ-007 in_ready  output  1  block can accept a vector.
REQ-008 x  input  BITSIZE*N  input vector; element k at x[BITSIZE*k +: BITSIZE].
REQ-009 out_valid  output  1  result vector y complete and stable.
REQ-010 out_ready  input  1  downstream accepts y.
REQ-011 y  output  BITSIZE*N  activated vector; element k at y[BITSIZE*k +: BITSIZE].
REQ-012 sat_cnt  output  4  count of elements clamped in the current result vector.

Function
REQ-013 Block SHALL implement a three-state FSM: IDLE, PROC, HOLD; all outputs registered.
REQ-014 In IDLE, in_ready SHALL be 1; in PROC and HOLD, in_ready SHALL be 0.
REQ-015 A transfer SHALL occur at a posedge with in_valid=1 and in_ready=1; x is captured into an internal register and the FSM moves to PROC with element index 0 and sat_cnt cleared to 0.
REQ-016 x changes after the acceptance edge SHALL NOT affect the result; in_valid outside IDLE SHALL be ignored.
REQ-017 In PROC, exactly one element (index 0..N-1 ascending) SHALL be computed and written to y per cycle; the index counter SHALL NOT wrap within a vector.
REQ-018 On the edge writing element N-1, the FSM SHALL enter HOLD and assert out_valid; out_valid first reads 1 exactly N cycles after the acceptance edge.
REQ-019 Per element: ONE = 1<<FRAC, HALF = 1<<(FRAC-1), TWO = 2<<FRAC; x >= TWO -> ONE; x <= -TWO -> 0; otherwise (x >>> 2) + HALF (arithmetic shift, truncation toward minus infinity); result is always within [0, ONE].
REQ-020 sat_cnt SHALL increment once per element taking either clamp branch (boundaries +/-TWO count as clamped); max value N.
REQ-021 In HOLD, y, sat_cnt and out_valid SHALL remain stable until a posedge with out_ready=1; then out_valid falls and the FSM returns to IDLE (one-cycle bubble before the next acceptance).
REQ-022 y and sat_cnt SHALL retain the last result after leaving HOLD until overwritten by the next PROC.

Reset
REQ-023 While reset=0 (asynchronously): FSM = IDLE, index = 0, captured x = 0, y = 0, sat_cnt = 0, out_valid = 0, in_ready = 1.
REQ-024 Reset asserted mid-PROC or mid-HOLD SHALL discard the partial or pending vector with no output handshake.

Verification
REQ-025 Hold reset=0 with in_valid=1 -> y=0, sat_cnt=0, out_valid=0, in_ready=1; no capture occurs; after release, first in_valid edge accepts.
REQ-026 Accept x all 0x0000 -> after 6 cycles out_valid=1, every y element 0x0080, sat_cnt=0.
REQ-027 Accept x elements 0..5 = {0x0200, 0xFE00, 0x0100, 0xFF00, 0x7FFF, 0x8000} -> y = {0x0100, 0x0000, 0x00C0, 0x0040, 0x0100, 0x0000}, sat_cnt=4.
REQ-028 Rounding: x elements 0x0003 and 0xFFFD (rest 0) -> y 0x0080 and 0x007F respectively; change x to all 0x7FFF on the edge after acceptance -> result unchanged.
REQ-029 Hold out_ready=0 five cycles in HOLD while pulsing in_valid -> out_valid, y, sat_cnt stable, in_ready=0, no new capture; out_ready=1 -> out_valid=0 next cycle, in_ready=1.
REQ-030 Assert reset during PROC at index 3 -> out_valid stays 0, y=0 immediately; after release, a fresh vector of all 0x0100 yields all 0x00C0 in 6 cycles.
